// File: rtl/zeroriscy_defines.sv
// Shared BNN definitions: operator encoding and unit pipeline depth.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package zeroriscy_defines;

  typedef enum logic [2:0] {
    BNN_INI  = 3'd0,
    BNN_ACC  = 3'd1,
    BNN_POOL = 3'd2,
    BNN_NORM = 3'd3,
    BNN_NOP  = 3'd7
  } bnn_op_e;

  // Cycles from an op being sampled until bnn_result reflects it.
  localparam int BNN_PIPE_LAT = 3;

endpackage

// File: rtl/zeroriscy_bnn_addr_gen.sv
// Counter/address block for the BNN layer sequencer: tracks j (input word),
// w (pool window), k (output word) and the running weight row.
// Latency: addresses are combinational from registered counters.
// Backpressure: counters only move on the step strobes from the FSM.
// Ports: clk/rst_n; load latches counts and bases; step_j/step_w/next_word
// advance counters; acc_addr/norm_addr are the param addresses; last_* flag
// the final value of each counter.
module zeroriscy_bnn_addr_gen
  import zeroriscy_defines::*;
#(
  parameter int AW = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step_j,
  input  logic          step_w,
  input  logic          next_word,
  input  logic [CW-1:0] n_in,
  input  logic [CW-1:0] n_pool,
  input  logic [CW-1:0] n_out,
  input  logic [AW-1:0] wbase,
  input  logic [AW-1:0] nbase,
  output logic [AW-1:0] acc_addr,
  output logic [AW-1:0] norm_addr,
  output logic          last_j,
  output logic          last_w,
  output logic          last_k
);

  logic [CW-1:0] n_in_q, n_pool_q, n_out_q;
  logic [CW-1:0] j, w, k;
  logic [AW-1:0] nbase_q, wrow;

  assign last_j    = (j == n_in_q - 1'b1);
  assign last_w    = (w == n_pool_q - 1'b1);
  assign last_k    = (k == n_out_q - 1'b1);
  // Address arithmetic wraps modulo 2^AW by construction.
  assign acc_addr  = wrow + AW'(j);
  assign norm_addr = nbase_q + AW'(k);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_in_q   <= '0;
      n_pool_q <= '0;
      n_out_q  <= '0;
      nbase_q  <= '0;
      wrow     <= '0;
      j        <= '0;
      w        <= '0;
      k        <= '0;
    end else if (load) begin
      n_in_q   <= n_in;
      n_pool_q <= n_pool;
      n_out_q  <= n_out;
      nbase_q  <= nbase;
      wrow     <= wbase;
      j        <= '0;
      w        <= '0;
      k        <= '0;
    end else begin
      // j and w wrap to 0 on their last value, so every new window/word
      // starts clean without an explicit clear from INI.
      if (step_j) j <= last_j ? '0 : j + 1'b1;
      if (step_w) w <= last_w ? '0 : w + 1'b1;
      if (next_word) begin
        k    <= k + 1'b1;
        wrow <= wrow + AW'(n_in_q);
      end
    end
  end

endmodule

// File: rtl/zeroriscy_bnn_seq.sv
// Layer sequencer feeding the BNN estimate unit: INI/ACC/POOL/NORM command
// stream per 32-neuron output word, pipeline drain, valid/ready result out.
// Latency: INI issued the cycle after start; result valid DRAIN+1 cycles after NORM.
// Backpressure: bnn_ready_i low or in_valid_i low (in ACC) stalls issue; out_ready_i low holds OUT.
// Ports: start/cfg_* layer config; in_* activation stream; bnn_* unit command
// and result; out_* result word; busy_o while running; done_o end-of-layer pulse.
module zeroriscy_bnn_seq
  import zeroriscy_defines::*;
#(
  parameter int AW    = 16,
  parameter int CW    = 8,
  parameter int DRAIN = BNN_PIPE_LAT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [CW-1:0] cfg_n_in_i,
  input  logic [CW-1:0] cfg_n_pool_i,
  input  logic [CW-1:0] cfg_n_out_i,
  input  logic [AW-1:0] cfg_wbase_i,
  input  logic [AW-1:0] cfg_nbase_i,
  input  logic [15:0]   cfg_bias_i,
  input  logic          in_valid_i,
  input  logic [31:0]   in_data_i,
  output logic          in_ready_o,
  output logic          bnn_en_o,
  output bnn_op_e       bnn_operator_o,
  output logic [31:0]   bnn_addr_o,
  output logic [31:0]   bnn_data_o,
  input  logic [31:0]   bnn_result_i,
  input  logic          bnn_ready_i,
  output logic          out_valid_o,
  output logic [31:0]   out_data_o,
  input  logic          out_ready_i,
  output logic          busy_o,
  output logic          done_o
);

  localparam int DCW = $clog2(DRAIN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INI, S_ACC, S_POOL, S_NORM, S_DRAIN, S_OUT
  } state_e;

  state_e         state;
  logic [15:0]    bias_q;
  logic [DCW-1:0] drain_cnt;
  logic [AW-1:0]  addr;
  logic [AW-1:0]  acc_addr, norm_addr;
  logic           last_j, last_w, last_k;
  logic           cfg_ok, load;

  assign cfg_ok = (|cfg_n_in_i) & (|cfg_n_pool_i) & (|cfg_n_out_i);
  assign load   = (state == S_IDLE) & start_i & cfg_ok;
  assign busy_o = (state != S_IDLE);

  zeroriscy_bnn_addr_gen #(.AW(AW), .CW(CW)) u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step_j    ((state == S_ACC) & bnn_en_o),
    .step_w    ((state == S_POOL) & bnn_en_o),
    .next_word ((state == S_OUT) & out_ready_i & ~last_k),
    .n_in      (cfg_n_in_i),
    .n_pool    (cfg_n_pool_i),
    .n_out     (cfg_n_out_i),
    .wbase     (cfg_wbase_i),
    .nbase     (cfg_nbase_i),
    .acc_addr  (acc_addr),
    .norm_addr (norm_addr),
    .last_j    (last_j),
    .last_w    (last_w),
    .last_k    (last_k)
  );

  // Command outputs depend on same-cycle bnn_ready_i/in_valid_i, so they are
  // decoded from the registered state rather than registered themselves.
  always_comb begin
    bnn_en_o       = 1'b0;
    bnn_operator_o = BNN_NOP;
    addr           = '0;
    bnn_data_o     = '0;
    in_ready_o     = 1'b0;
    if (bnn_ready_i) begin
      case (state)
        S_INI: begin
          bnn_en_o       = 1'b1;
          bnn_operator_o = BNN_INI;
          bnn_data_o     = {16'h0, bias_q};
        end
        S_ACC: if (in_valid_i) begin
          bnn_en_o       = 1'b1;
          bnn_operator_o = BNN_ACC;
          addr           = acc_addr;
          bnn_data_o     = in_data_i;
          in_ready_o     = 1'b1;
        end
        S_POOL: begin
          bnn_en_o       = 1'b1;
          bnn_operator_o = BNN_POOL;
          bnn_data_o     = {16'h0, bias_q};
        end
        S_NORM: begin
          bnn_en_o       = 1'b1;
          bnn_operator_o = BNN_NORM;
          addr           = norm_addr;
        end
        default: ;
      endcase
    end
  end

  assign bnn_addr_o = 32'(addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      bias_q      <= '0;
      drain_cnt   <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      done_o      <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: if (start_i) begin
          if (cfg_ok) begin
            bias_q <= cfg_bias_i;
            state  <= S_INI;
          end else begin
            done_o <= 1'b1;  // empty layer completes immediately
          end
        end
        S_INI:  if (bnn_en_o) state <= S_ACC;
        S_ACC:  if (bnn_en_o && last_j) state <= S_POOL;
        S_POOL: if (bnn_en_o) state <= last_w ? S_NORM : S_ACC;
        S_NORM: if (bnn_en_o) begin
          drain_cnt <= DCW'(DRAIN);
          state     <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_cnt <= DCW'(1)) begin
            out_data_o  <= bnn_result_i;
            out_valid_o <= 1'b1;
            state       <= S_OUT;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        S_OUT: if (out_ready_i) begin
          out_valid_o <= 1'b0;
          if (last_k) begin
            done_o <= 1'b1;
            state  <= S_IDLE;
          end else begin
            state <= S_INI;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
